// File: rtl/asps_pkg.sv
// Shared definitions for the Alamein Smart Parking System entry and exit sides.
package asps_pkg;

  localparam int ID_W            = 2;
  localparam int FEE_W           = 8;
  localparam int REV_W           = 16;
  localparam int COST_RATE_DEF   = 2;
  localparam int TICK_CYCLES_DEF = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    CALC   = 3'd2,
    BILL   = 3'd3,
    GATE   = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/asps_fee_calc.sv
// Combinational elapsed-time to fee conversion with minimum charge and 8-bit ceiling.
module asps_fee_calc
  import asps_pkg::*;
#(
  parameter int COST_RATE   = COST_RATE_DEF,
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int TS_W        = 32
) (
  input  logic [TS_W-1:0]  elapsed,
  output logic [FEE_W-1:0] fee
);

  // Product is widened so a huge elapsed time can never wrap back into range.
  localparam int RAW_W = TS_W + 16;
  localparam logic [FEE_W-1:0] FEE_MAX = '1;

  logic [TS_W-1:0]  units;
  logic [RAW_W-1:0] raw;

  // A zero charge is bumped to one tick's worth; anything past 8 bits clamps.
  function automatic logic [FEE_W-1:0] sat_fee(input logic [RAW_W-1:0] r);
    if (r == '0)
      return FEE_W'(COST_RATE);
    else if (r > RAW_W'(FEE_MAX))
      return FEE_MAX;
    else
      return r[FEE_W-1:0];
  endfunction

  // Whole billing ticks elapsed, priced and clamped.
  always_comb begin
    units = elapsed / TS_W'(TICK_CYCLES);
    raw   = RAW_W'(units) * RAW_W'(COST_RATE);
    fee   = sat_fee(raw);
  end

endmodule

// File: rtl/asps_exit_billing.sv
// Exit gate controller: looks up entry time, bills, waits for payment, opens gate, commits.
module asps_exit_billing
  import asps_pkg::*;
#(
  parameter int COST_RATE   = COST_RATE_DEF,
  parameter int TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int GATE_CYCLES = 4,
  parameter int PAY_TIMEOUT = 64,
  parameter int TS_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exit_detected,
  input  logic [ID_W-1:0]  id,
  input  logic [1:0]       car_count,
  input  logic [TS_W-1:0]  now,
  output logic [ID_W-1:0]  ts_rd_addr,
  input  logic [TS_W-1:0]  ts_rd_data,
  output logic [FEE_W-1:0] fee,
  output logic             fee_valid,
  input  logic             fee_ack,
  output logic             gate_open,
  output logic             exit_commit,
  output logic             exit_reject,
  output logic             pay_timeout,
  output logic             busy,
  output logic [REV_W-1:0] revenue
);

  localparam int CNT_MAX = (PAY_TIMEOUT > GATE_CYCLES) ? PAY_TIMEOUT : GATE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [TS_W-1:0]   t_exit_p0;
  logic [TS_W-1:0]   ts_p1;
  logic [FEE_W-1:0]  fee_calc;
  logic              accept, reject, bill_timeout;

  // Revenue sticks at full scale rather than wrapping.
  function automatic logic [REV_W-1:0] sat_rev(input logic [REV_W-1:0] acc,
                                               input logic [FEE_W-1:0] add);
    logic [REV_W:0] sum;
    sum = {1'b0, acc} + {{(REV_W + 1 - FEE_W){1'b0}}, add};
    return sum[REV_W] ? '1 : sum[REV_W-1:0];
  endfunction

  asps_fee_calc #(
    .COST_RATE   (COST_RATE),
    .TICK_CYCLES (TICK_CYCLES),
    .TS_W        (TS_W)
  ) u_fee_calc (
    .elapsed (t_exit_p0 - ts_p1),
    .fee     (fee_calc)
  );

  // Flag outputs decode straight from the state register so reset clears them at once.
  assign fee_valid   = (state == BILL);
  assign gate_open   = (state == GATE);
  assign exit_commit = (state == DONE);
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; any exit event arriving mid-transaction is refused.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    reject       = 1'b0;
    bill_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (exit_detected) begin
          if (car_count == '0 || id == '0) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = LOOKUP;
          end
        end
      end
      LOOKUP: state_nxt = CALC;
      CALC:   state_nxt = BILL;
      BILL: begin
        if (fee_ack) begin
          state_nxt = GATE;
        end else if (cnt == PAY_LAST) begin
          state_nxt    = IDLE;
          bill_timeout = 1'b1;
        end
      end
      GATE:    if (cnt == GATE_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (exit_detected && state != IDLE) reject = 1'b1;
  end

  // p0: exit time latched on accept; p1: entry time captured in LOOKUP; fee registered in CALC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_rd_addr  <= '0;
      t_exit_p0   <= '0;
      ts_p1       <= '0;
      fee         <= '0;
      revenue     <= '0;
      cnt         <= '0;
      exit_reject <= 1'b0;
      pay_timeout <= 1'b0;
    end else begin
      exit_reject <= reject;
      pay_timeout <= bill_timeout;
      if (accept) begin
        ts_rd_addr <= id;
        t_exit_p0  <= now;
      end
      if (state == LOOKUP) ts_p1 <= ts_rd_data;
      if (state == CALC)   fee   <= fee_calc;
      if (state == BILL && fee_ack) revenue <= sat_rev(revenue, fee);
      if (state_nxt != state)
        cnt <= '0;
      else if (state == BILL || state == GATE)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_asps_exit_billing.sv
// Self-checking bench for asps_exit_billing with a behavioural fee/revenue model.
module tb_asps_exit_billing;

  localparam int COST = 2;
  localparam int TICK = 10;
  localparam int GATE_N = 4;
  localparam int PAY_N = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exit_detected = 1'b0;
  logic [1:0]  id = '0;
  logic [1:0]  car_count = '0;
  logic [31:0] now = '0;
  logic [1:0]  ts_rd_addr;
  logic [31:0] ts_rd_data;
  logic [7:0]  fee;
  logic        fee_valid;
  logic        fee_ack = 1'b0;
  logic        gate_open, exit_commit, exit_reject, pay_timeout, busy;
  logic [15:0] revenue;

  logic [31:0] ts_table [4];
  int checks = 0;
  int failures = 0;
  int exp_rev = 0;

  always #5 clk = ~clk;

  // Entry-side timestamp table: read data follows the address within the lookup cycle.
  assign ts_rd_data = ts_table[ts_rd_addr];

  asps_exit_billing dut (
    .clk(clk), .reset(reset), .exit_detected(exit_detected), .id(id),
    .car_count(car_count), .now(now), .ts_rd_addr(ts_rd_addr), .ts_rd_data(ts_rd_data),
    .fee(fee), .fee_valid(fee_valid), .fee_ack(fee_ack), .gate_open(gate_open),
    .exit_commit(exit_commit), .exit_reject(exit_reject), .pay_timeout(pay_timeout),
    .busy(busy), .revenue(revenue)
  );

  // Reference price: whole ticks times rate, at least one rate, at most 255.
  function automatic int model_fee(input logic [31:0] ts, input logic [31:0] tx);
    logic [31:0] el;
    longint raw;
    el  = tx - ts;
    raw = longint'(el / TICK) * COST;
    if (raw == 0) return COST;
    if (raw > 255) return 255;
    return int'(raw);
  endfunction

  function automatic int model_add(input int acc, input int f);
    return (acc + f > 65535) ? 65535 : acc + f;
  endfunction

  // Runs one exit event and records what the DUT did, cycle by cycle.
  task automatic drive_exit(input logic [1:0] cid, input logic [1:0] cc,
                            input logic [31:0] ts, input logic [31:0] tx,
                            input int ack_dly, input bit inject,
                            output int lat, output int fee_seen, output int fee_unstable,
                            output int bill_cyc, output int gates, output int commits,
                            output int tos, output int rejects, output bit done);
    bit injected;
    @(negedge clk);
    for (int k = 0; k < 4; k++) ts_table[k] = $urandom;
    ts_table[cid] = ts;
    now = tx; id = cid; car_count = cc; exit_detected = 1'b1;
    lat = -1; fee_seen = -1; fee_unstable = 0; bill_cyc = 0; gates = 0;
    commits = 0; tos = 0; rejects = 0; done = 1'b0; injected = 1'b0;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      exit_detected = 1'b0;
      if (exit_reject) rejects++;
      if (pay_timeout) tos++;
      if (gate_open) gates++;
      if (exit_commit) commits++;
      if (fee_valid) begin
        if (lat < 0) begin lat = n; fee_seen = int'(fee); end
        else if (int'(fee) != fee_seen) fee_unstable++;
        bill_cyc++;
        fee_ack = (ack_dly >= 0 && bill_cyc >= ack_dly + 1);
      end else begin
        fee_ack = 1'b0;
      end
      if (inject && gate_open && !injected) begin
        exit_detected = 1'b1; id = 2'd2; car_count = 2'd3; injected = 1'b1;
      end
      if (!busy && n >= 2 && !exit_detected) begin done = 1'b1; break; end
    end
    fee_ack = 1'b0; exit_detected = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({fee_valid, gate_open, exit_commit, exit_reject, pay_timeout, busy} !== 6'b0) begin
      failures++; $display("FAIL reset_flags got=%b expected=000000",
        {fee_valid, gate_open, exit_commit, exit_reject, pay_timeout, busy});
    end
    checks++;
    if (fee !== 8'd0 || ts_rd_addr !== 2'd0) begin
      failures++; $display("FAIL reset_fee_addr got fee=%0d addr=%0d expected 0 0", fee, ts_rd_addr);
    end
    checks++;
    if (revenue !== 16'd0) begin
      failures++; $display("FAIL reset_revenue got=%0d expected=0", revenue);
    end
  endtask

  task automatic test_basic;
    int lat, f, unst, bc, g, c, t, r; bit d;
    drive_exit(2'd1, 2'd3, 32'd100, 32'd160, 2, 1'b0, lat, f, unst, bc, g, c, t, r, d);
    exp_rev = model_add(exp_rev, 12);
    checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d expected=3", lat); end
    checks++; if (f !== 12) begin failures++; $display("FAIL basic_fee got=%0d expected=12", f); end
    checks++; if (unst !== 0 || bc !== 3) begin failures++; $display("FAIL basic_bill got unstable=%0d cycles=%0d expected 0 3", unst, bc); end
    checks++; if (g !== GATE_N) begin failures++; $display("FAIL basic_gate got=%0d expected=%0d", g, GATE_N); end
    checks++; if (c !== 1 || t !== 0 || r !== 0 || !d) begin failures++; $display("FAIL basic_pulses got commit=%0d to=%0d rej=%0d done=%0d expected 1 0 0 1", c, t, r, d); end
    checks++; if (int'(revenue) !== exp_rev) begin failures++; $display("FAIL basic_revenue got=%0d expected=%0d", revenue, exp_rev); end
  endtask

  task automatic test_fee_bounds;
    int lat, f, unst, bc, g, c, t, r; bit d;
    logic [31:0] tsv [3];
    logic [31:0] txv [3];
    tsv[0] = 32'd5000;       txv[0] = 32'd5000;
    tsv[1] = 32'd1000;       txv[1] = 32'd3000;
    tsv[2] = 32'hFFFF_FFF0;  txv[2] = 32'h0000_0040;
    for (int i = 0; i < 3; i++) begin
      drive_exit(2'(i + 1), 2'd2, tsv[i], txv[i], 0, 1'b0, lat, f, unst, bc, g, c, t, r, d);
      exp_rev = model_add(exp_rev, model_fee(tsv[i], txv[i]));
      checks++;
      if (f !== model_fee(tsv[i], txv[i])) begin
        failures++; $display("FAIL bound_fee[%0d] got=%0d expected=%0d", i, f, model_fee(tsv[i], txv[i]));
      end
    end
    checks++; if (int'(revenue) !== exp_rev) begin failures++; $display("FAIL bound_revenue got=%0d expected=%0d", revenue, exp_rev); end
  endtask

  task automatic test_reject;
    int lat, f, unst, bc, g, c, t, r; bit d;
    logic [1:0] addr_before;
    // fee_ack with nothing on offer must be ignored
    fee_ack = 1'b1;
    repeat (3) @(negedge clk);
    fee_ack = 1'b0;
    checks++; if (int'(revenue) !== exp_rev || gate_open !== 1'b0) begin failures++; $display("FAIL idle_ack got rev=%0d gate=%0d expected %0d 0", revenue, gate_open, exp_rev); end
    addr_before = ts_rd_addr;
    drive_exit(2'd3, 2'd0, 32'd0, 32'd500, 0, 1'b0, lat, f, unst, bc, g, c, t, r, d);
    checks++; if (r !== 1 || lat !== -1 || c !== 0) begin failures++; $display("FAIL reject_empty got rej=%0d lat=%0d commit=%0d expected 1 -1 0", r, lat, c); end
    checks++; if (ts_rd_addr !== addr_before) begin failures++; $display("FAIL reject_addr got=%0d expected=%0d", ts_rd_addr, addr_before); end
    drive_exit(2'd0, 2'd2, 32'd0, 32'd500, 0, 1'b0, lat, f, unst, bc, g, c, t, r, d);
    checks++; if (r !== 1 || lat !== -1 || g !== 0) begin failures++; $display("FAIL reject_id0 got rej=%0d lat=%0d gate=%0d expected 1 -1 0", r, lat, g); end
  endtask

  task automatic test_busy_reject;
    int lat, f, unst, bc, g, c, t, r; bit d;
    drive_exit(2'd3, 2'd3, 32'd40, 32'd275, 1, 1'b1, lat, f, unst, bc, g, c, t, r, d);
    exp_rev = model_add(exp_rev, model_fee(32'd40, 32'd275));
    checks++; if (r !== 1 || c !== 1 || g !== GATE_N) begin failures++; $display("FAIL busy_reject got rej=%0d commit=%0d gate=%0d expected 1 1 %0d", r, c, g, GATE_N); end
    checks++; if (f !== 46 || int'(revenue) !== exp_rev) begin failures++; $display("FAIL busy_fee got fee=%0d rev=%0d expected 46 %0d", f, revenue, exp_rev); end
  endtask

  task automatic test_timeout;
    int lat, f, unst, bc, g, c, t, r; bit d;
    drive_exit(2'd2, 2'd1, 32'd0, 32'd77, -1, 1'b0, lat, f, unst, bc, g, c, t, r, d);
    checks++; if (t !== 1 || bc !== PAY_N || !d) begin failures++; $display("FAIL timeout_pulse got to=%0d bill=%0d done=%0d expected 1 %0d 1", t, bc, d, PAY_N); end
    checks++; if (g !== 0 || c !== 0 || int'(revenue) !== exp_rev) begin failures++; $display("FAIL timeout_effects got gate=%0d commit=%0d rev=%0d expected 0 0 %0d", g, c, revenue, exp_rev); end
  endtask

  task automatic test_random;
    int lat, f, unst, bc, g, c, t, r; bit d;
    logic [31:0] ts, el;
    int bad = 0;
    for (int i = 0; i < 24; i++) begin
      ts = $urandom;
      el = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1500));
      drive_exit(2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)), ts, ts + el,
                 $urandom_range(0, 10), 1'b0, lat, f, unst, bc, g, c, t, r, d);
      exp_rev = model_add(exp_rev, model_fee(ts, ts + el));
      checks++;
      if (f !== model_fee(ts, ts + el) || g !== GATE_N || c !== 1 || int'(revenue) !== exp_rev || unst !== 0) begin
        failures++; bad++;
        $display("FAIL random[%0d] got fee=%0d gate=%0d commit=%0d rev=%0d expected %0d %0d 1 %0d",
                 i, f, g, c, revenue, model_fee(ts, ts + el), GATE_N, exp_rev);
      end
    end
  endtask

  task automatic test_revenue_sat;
    int lat, f, unst, bc, g, c, t, r; bit d;
    while (exp_rev < 65535) begin
      drive_exit(2'd1, 2'd3, 32'd0, 32'd5000, 0, 1'b0, lat, f, unst, bc, g, c, t, r, d);
      exp_rev = model_add(exp_rev, 255);
    end
    checks++; if (revenue !== 16'hFFFF) begin failures++; $display("FAIL revenue_sat got=%0d expected=65535", revenue); end
    drive_exit(2'd2, 2'd3, 32'd0, 32'd30, 0, 1'b0, lat, f, unst, bc, g, c, t, r, d);
    checks++; if (revenue !== 16'hFFFF || c !== 1) begin failures++; $display("FAIL revenue_hold got=%0d commit=%0d expected 65535 1", revenue, c); end
  endtask

  task automatic test_reset_mid;
    int lat, f, unst, bc, g, c, t, r; bit d;
    int wait_n = 0;
    @(negedge clk);
    ts_table[1] = 32'd10; now = 32'd90; id = 2'd1; car_count = 2'd2; exit_detected = 1'b1;
    @(negedge clk);
    exit_detected = 1'b0;
    while (!fee_valid && wait_n < 10) begin @(negedge clk); wait_n++; end
    checks++; if (fee_valid !== 1'b1) begin failures++; $display("FAIL midreset_reach_bill got=%0d expected=1", fee_valid); end
    reset = 1'b1;
    #1;
    checks++;
    if ({fee_valid, gate_open, exit_commit, exit_reject, pay_timeout, busy} !== 6'b0 ||
        fee !== 8'd0 || revenue !== 16'd0 || ts_rd_addr !== 2'd0) begin
      failures++; $display("FAIL midreset_clear got flags=%b fee=%0d rev=%0d addr=%0d expected all zero",
        {fee_valid, gate_open, exit_commit, exit_reject, pay_timeout, busy}, fee, revenue, ts_rd_addr);
    end
    exp_rev = 0;
    @(negedge clk);
    reset = 1'b0;
    drive_exit(2'd1, 2'd3, 32'd100, 32'd160, 0, 1'b0, lat, f, unst, bc, g, c, t, r, d);
    exp_rev = model_add(exp_rev, 12);
    checks++; if (f !== 12 || c !== 1 || int'(revenue) !== exp_rev) begin failures++; $display("FAIL postreset got fee=%0d commit=%0d rev=%0d expected 12 1 %0d", f, c, revenue, exp_rev); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) ts_table[k] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_basic();
    test_fee_bounds();
    test_reject();
    test_busy_reject();
    test_timeout();
    test_random();
    test_revenue_sat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/asps_exit_billing.md
Name: asps_exit_billing

Overview:
Exit-side billing and gate controller for the Alamein Smart Parking System. Consumes the exit event that ASPS_Top raises for a departing car and reads that car's entry timestamp from the shared timestamp table written at the entry gate. Computes the parking fee, presents it to the payment terminal over a valid/ack handshake, opens the exit barrier, then commits the departure back to the occupancy counter.

Parameters:
COST_RATE, 2, fee units per billing tick
TICK_CYCLES, 10, clock cycles per billing tick
GATE_CYCLES, 4, cycles gate_open is held high
PAY_TIMEOUT, 64, max cycles waiting for fee_ack before abort
TS_W, 32, timestamp width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
exit_detected  in  1  single-cycle pulse, car at exit beam
id  in  2  car id, sampled with exit_detected (valid ids 1..3)
car_count  in  2  current occupancy from ASPS_Top
now  in  TS_W  free-running timebase shared with entry side
ts_rd_addr  out  2  timestamp table read address
ts_rd_data  in  TS_W  entry timestamp, valid 1 cycle after ts_rd_addr
fee  out  8  computed fee, stable while fee_valid
fee_valid  out  1  fee offered to payment terminal
fee_ack  in  1  terminal accepts fee (handshake completes when fee_valid & fee_ack)
gate_open  out  1  exit barrier drive
exit_commit  out  1  1-cycle pulse: decrement occupancy
exit_reject  out  1  1-cycle pulse: event ignored
pay_timeout  out  1  1-cycle pulse: payment abandoned
busy  out  1  high in any state other than IDLE
revenue  out  16  accumulated accepted fees, saturating

Behaviour:
- Reset (async): state=IDLE; fee, fee_valid, gate_open, exit_commit, exit_reject, pay_timeout, busy, ts_rd_addr = 0; revenue = 0.
- IDLE: on exit_detected, if car_count==0 or id==0, pulse exit_reject next cycle and stay in IDLE. Otherwise latch id, latch now as t_exit, drive ts_rd_addr=id, go to LOOKUP.
- LOOKUP (1 cycle): capture ts_rd_data, go to CALC.
- CALC (1 cycle): elapsed = t_exit - ts (modulo 2^TS_W, so timebase wrap is handled); units = elapsed / TICK_CYCLES (integer); raw = units*COST_RATE; if raw==0 then fee=COST_RATE; if raw>255 then fee=255. Go to BILL.
- BILL: fee_valid=1, fee held stable. On fee_valid&fee_ack: revenue += fee (saturate at 16'hFFFF), drop fee_valid, go to GATE. After PAY_TIMEOUT cycles without ack: drop fee_valid, pulse pay_timeout, go to IDLE with no commit and no revenue change.
- GATE: gate_open=1 for exactly GATE_CYCLES cycles, then go to DONE.
- DONE: exit_commit=1 for one cycle, then go to IDLE.
- Latency, exit_detected to fee_valid: 3 cycles.
- exit_detected while busy: ignored, exit_reject pulses; the in-flight transaction is unaffected.
- fee_ack outside BILL: ignored.
- Reset mid-transaction: immediate abort, no commit, revenue cleared.

Decomposition:
- Shared package asps_pkg: state enum (IDLE, LOOKUP, CALC, BILL, GATE, DONE), car-id width, fee width, and COST_RATE/TICK_CYCLES defaults shared with the entry side.
- Sub-module asps_fee_calc: combinational elapsed→fee with min/saturation rules, reused by the entry-side display path.

Test Plan:
- ts=100, exit at now=160, id=1, car_count=3, ack 2 cycles after fee_valid -> fee=12, gate_open 4 cycles, one exit_commit, revenue=12.
- ts==now (elapsed 0) -> fee=2 (minimum); elapsed 2000 -> fee=255 (saturated).
- car_count=0, exit_detected -> exit_reject pulse, fee_valid never asserted, ts_rd_addr unchanged.
- Second exit_detected during GATE -> exit_reject, first transaction completes with a single exit_commit.
- No fee_ack for 64 cycles -> pay_timeout pulse, no gate_open, no commit, revenue unchanged.
- reset asserted during BILL -> all outputs 0 immediately; next exit is processed normally from IDLE.
